// File: rtl/seq_divider_26by13_pkg.sv
// Shared constants and types for the 26-by-13 sequential restoring divider.
package div_pkg;

  // Operand width: dividend is 2N bits, quotient and remainder are N bits.
  localparam int N     = 13;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Registered result as presented on the output side of the handshake.
  typedef struct packed {
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
  } result_t;

endpackage

// File: rtl/seq_divider_26by13_if.sv
// Operand/result handshake bundle between the divide sequencer and the divider.
interface seq_divider_26by13_if;
  import div_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  // Sequencer side: issues operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider_26by13_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step
  import div_pkg::*;
(
  input  logic [N:0]   rem,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_nxt,
  output logic         q_bit
);

  logic [N:0] t;

  // rem[N] is the bit shifted out of T; if it were ever set, T would exceed
  // any N-bit divisor, so it forces the subtract. With rem < divisor it stays 0.
  always_comb begin
    t       = {rem[N-1:0], bit_in};
    q_bit   = rem[N] | (t >= {1'b0, divisor});
    rem_nxt = q_bit ? (t - {1'b0, divisor}) : t;
  end

endmodule

// File: rtl/seq_divider_26by13.sv
// Sequential unsigned restoring divider, 2N/N -> N quotient + N remainder,
// one quotient bit per clock behind a valid/ready handshake.
module seq_divider_26by13
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  seq_divider_26by13_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       rem_q;
  logic [N-1:0]     shreg;
  logic [N-1:0]     dvsr;
  logic             exc_dbz, exc_ovf;
  result_t          res;

  logic             accept, take, exc, last_step;
  logic [N:0]       rem_nxt;
  logic             q_bit;

  assign accept    = bus.in_valid && bus.in_ready;
  assign take      = bus.out_valid && bus.out_ready;
  assign exc       = exc_dbz | exc_ovf;
  assign last_step = (cnt == CNT_W'(N-1));

  div_restore_step u_step (
    .rem     (rem_q),
    .bit_in  (shreg[N-1]),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. Exceptions spend one cycle in CALC so the result path is the
  // same registered load as a normal divide.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)           state_nxt = CALC;
      CALC:    if (exc || last_step)       state_nxt = DONE;
      DONE:    if (bus.out_ready)          state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Operand capture and the per-step remainder/shift update. The shift
  // register feeds dividend bits out of its MSB and collects quotient bits
  // at its LSB, so after N steps it holds the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem_q   <= '0;
      shreg   <= '0;
      dvsr    <= '0;
      exc_dbz <= 1'b0;
      exc_ovf <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      rem_q   <= {1'b0, bus.dividend[2*N-1:N]};
      shreg   <= bus.dividend[N-1:0];
      dvsr    <= bus.divisor;
      exc_dbz <= (bus.divisor == '0);
      exc_ovf <= (bus.divisor != '0) && (bus.dividend[2*N-1:N] >= bus.divisor);
    end else if (state == CALC && !exc) begin
      cnt   <= cnt + 1'b1;
      rem_q <= rem_nxt;
      shreg <= {shreg[N-2:0], q_bit};
    end
  end

  // Result registers: loaded on the way into DONE, held until taken; the
  // flags clear on transfer so they never leak into the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (state == CALC) begin
      if (exc) begin
        res.quotient    <= '1;
        res.remainder   <= exc_dbz ? shreg : '0;
        res.div_by_zero <= exc_dbz;
        res.overflow    <= exc_ovf;
      end else if (last_step) begin
        res.quotient    <= {shreg[N-2:0], q_bit};
        res.remainder   <= rem_nxt[N-1:0];
        res.div_by_zero <= 1'b0;
        res.overflow    <= 1'b0;
      end
    end else if (take) begin
      res.div_by_zero <= 1'b0;
      res.overflow    <= 1'b0;
    end
  end

  assign bus.quotient    = res.quotient;
  assign bus.remainder   = res.remainder;
  assign bus.div_by_zero = res.div_by_zero;
  assign bus.overflow    = res.overflow;

endmodule

// File: tb/tb_seq_divider_26by13.sv
// Scoreboard bench for the 26-by-13 sequential divider.
module tb_seq_divider_26by13;
  import div_pkg::*;

  typedef struct {
    logic [2*N-1:0] dd;
    logic [N-1:0]   dv;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           dbz;
    logic           ovf;
    int             lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seq_divider_26by13_if bus();

  seq_divider_26by13 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Crosswise (urdhva-tiryak) multiply: column k sums a[i]&b[k-i], then shifts.
  function automatic logic [2*N-1:0] vedic_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    logic [2*N-1:0] col;
    p = '0;
    for (int k = 0; k < 2*N-1; k++) begin
      col = '0;
      for (int i = 0; i < N; i++) begin
        if (k - i >= 0 && k - i < N) col += (2*N)'(a[i] & b[k-i]);
      end
      p += col << k;
    end
    return p;
  endfunction

  task automatic send(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    exp_t e;
    int   n;
    e.dd = dd;
    e.dv = dv;
    if (dv == '0) begin
      e.q = '1; e.r = dd[N-1:0]; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else if (dd[2*N-1:N] >= dv) begin
      e.q = '1; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q = N'(dd / (2*N)'(dv)); e.r = N'(dd % (2*N)'(dv));
      e.dbz = 1'b0; e.ovf = 1'b0; e.lat = N;
    end
    sb.push_back(e);
    @(negedge clk);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble operands right after acceptance: the divider must ignore them.
    bus.in_valid = 1'b0;
    bus.dividend = (2*N)'($urandom);
    bus.divisor  = N'($urandom);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_take", 32'(bus.out_valid), 32'd0);
    chk("dbz_cleared", 32'(bus.div_by_zero), 32'd0);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
  endtask

  task automatic collect(input bit take_now);
    exp_t e;
    int   lat;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("quotient", 32'(bus.quotient), 32'(e.q));
    chk("remainder", 32'(bus.remainder), 32'(e.r));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
    chk("overflow", 32'(bus.overflow), 32'(e.ovf));
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    if (!e.dbz && !e.ovf) begin
      chk("roundtrip", 32'(vedic_mul(bus.quotient, e.dv) + (2*N)'(bus.remainder)), 32'(e.dd));
      chk("rem_lt_div", 32'(bus.remainder < e.dv), 32'd1);
    end
    if (take_now) release_result();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           seen;
    logic [N-1:0]   dv, hi;
    logic [2*N-1:0] dd;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    send(26'd1000, 13'd7);         collect(1'b1);
    send(26'd67092480, 13'd8191);  collect(1'b1);
    send(26'd12345, 13'd0);        collect(1'b1);
    send(26'd40960, 13'd5);        collect(1'b1);

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    send(26'd5000, 13'd9);
    collect(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.dividend = 26'd777;
      bus.divisor  = 13'd3;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_quotient", 32'(bus.quotient), 32'd555);
      chk("bp_remainder", 32'(bus.remainder), 32'd5);
    end
    bus.in_valid = 1'b0;
    release_result();
    @(negedge clk);
    chk("bp_no_second_result", 32'(bus.out_valid), 32'd0);

    // Reset mid-CALC aborts with no output pulse.
    send(26'd1000, 13'd7);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    chk("abort_ovf", 32'(bus.overflow), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);

    // Random non-exception operands.
    for (int i = 0; i < 2000; i++) begin
      dv = N'($urandom_range(1, (1 << N) - 1));
      hi = N'($urandom_range(0, int'(dv) - 1));
      dd = {hi, N'($urandom)};
      send(dd, dv);
      collect(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
